full_adder_samp: RTL and testbench

FULL_ADDER_SAMP -- requirements
Module: full_adder_samp

---
 rtl/full_adder_samp_pkg.sv | 14 +
 rtl/full_adder_samp_fa_cell.sv | 14 +
 rtl/full_adder_samp.sv | 71 +++++++
 tb/tb_full_adder_samp.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_samp_pkg.sv
// Shared constants for the registered ripple-carry adder block.
// The optional sum_par output of full_adder_samp is enabled with FULL_ADDER_SAMP_PARITY_EN.
package full_adder_samp_pkg;

   localparam int WIDTH_DEF = 1;
   localparam int CNT_W     = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // The carry counter sticks at its maximum rather than wrapping back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/full_adder_samp_fa_cell.sv
// One-bit combinational full adder cell.
// full_adder_samp chains WIDTH of these cells into a ripple-carry adder.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/full_adder_samp.sv
// Registered WIDTH-bit ripple-carry adder with carry-out, signed overflow and a saturating carry counter.
// Define FULL_ADDER_SAMP_PARITY_EN to add the registered even-parity output sum_par.
module full_adder_samp
   import full_adder_samp_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             out_valid,
   output logic [CNT_W-1:0] carry_cnt
`ifdef FULL_ADDER_SAMP_PARITY_EN
   ,
   output logic             sum_par
`endif
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_comb;

   assign carry[0] = c_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      fa_cell u_cell (
         .a  (a_in[i]),
         .b  (b_in[i]),
         .ci (carry[i]),
         .s  (sum_comb[i]),
         .co (carry[i+1])
      );
   end

   // Result registers only load on accepted operands, so idle-cycle operand values never reach the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum       <= '0;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         carry_cnt <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum   <= sum_comb;
            c_out <= carry[WIDTH];
            ovf   <= carry[WIDTH] ^ carry[WIDTH-1];
            if (carry[WIDTH]) begin
               carry_cnt <= sat_inc(carry_cnt);
            end
         end
      end
   end

`ifdef FULL_ADDER_SAMP_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_par <= 1'b0;
      end else if (in_valid) begin
         sum_par <= ^sum_comb;
      end
   end
`endif

endmodule

// File: tb/tb_full_adder_samp.sv
// Testbench for full_adder_samp: a 1-bit and an 8-bit instance fed from vector tables,
// plus hand-written hold, mid-stream reset and counter saturation sequences.
module tb_full_adder_samp;
   import full_adder_samp_pkg::*;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   typedef struct {
      logic [7:0] s;
      logic       co;
      logic       ov;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       in_valid1, c1, in_valid8, c8;
   logic [0:0] a1, b1, sum1;
   logic [7:0] a8, b8, sum8;
   logic       c_out1, ovf1, out_valid1, c_out8, ovf8, out_valid8;
   logic [CNT_W-1:0] carry_cnt1, carry_cnt8;
`ifdef FULL_ADDER_SAMP_PARITY_EN
   logic sum_par1, sum_par8;
`endif

   full_adder_samp #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .a_in(a1), .b_in(b1), .c_in(c1),
      .sum(sum1), .c_out(c_out1), .ovf(ovf1), .out_valid(out_valid1), .carry_cnt(carry_cnt1)
`ifdef FULL_ADDER_SAMP_PARITY_EN
      , .sum_par(sum_par1)
`endif
   );

   full_adder_samp #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .a_in(a8), .b_in(b8), .c_in(c8),
      .sum(sum8), .c_out(c_out8), .ovf(ovf8), .out_valid(out_valid8), .carry_cnt(carry_cnt8)
`ifdef FULL_ADDER_SAMP_PARITY_EN
      , .sum_par(sum_par8)
`endif
   );

   exp_t q1[$];
   exp_t q8[$];
   exp_t e1, e8;
   int check_count = 0;
   int fail_count  = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_count++;
      if (act !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
      end
   endtask

   // Reference result: wide add plus the sign rule for two's-complement overflow.
   function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b, input logic c);
      exp_t       e;
      logic [7:0] mask;
      logic [8:0] full;
      mask = (w == 8) ? 8'hFF : 8'h01;
      full = {1'b0, a & mask} + {1'b0, b & mask} + {8'd0, c};
      e.s  = full[7:0] & mask;
      e.co = (w == 8) ? full[8] : full[1];
      e.ov = (a[w-1] == b[w-1]) && (e.s[w-1] != a[w-1]);
      return e;
   endfunction

   task automatic applyStimulus(input int w, input logic v, input logic [7:0] a, input logic [7:0] b,
                                input logic c, input exp_t e);
      @(negedge clk);
      if (w == 1) begin
         in_valid1 = v; a1 = a[0:0]; b1 = b[0:0]; c1 = c;
         if (v) q1.push_back(e);
      end else begin
         in_valid8 = v; a8 = a; b8 = b; c8 = c;
         if (v) q8.push_back(e);
      end
   endtask

   // Scoreboard for the 1-bit instance.
   always @(negedge clk) begin
      if (out_valid1) begin
         if (q1.size() == 0) begin
            checkOutput("w1 unexpected out_valid", 32'(out_valid1), 32'd0);
         end else begin
            e1 = q1.pop_front();
            checkOutput("w1 sum", 32'(sum1), 32'(e1.s[0]));
            checkOutput("w1 c_out", 32'(c_out1), 32'(e1.co));
            checkOutput("w1 ovf", 32'(ovf1), 32'(e1.ov));
`ifdef FULL_ADDER_SAMP_PARITY_EN
            checkOutput("w1 sum_par", 32'(sum_par1), 32'(e1.s[0]));
`endif
         end
      end
   end

   // Scoreboard for the 8-bit instance.
   always @(negedge clk) begin
      if (out_valid8) begin
         if (q8.size() == 0) begin
            checkOutput("w8 unexpected out_valid", 32'(out_valid8), 32'd0);
         end else begin
            e8 = q8.pop_front();
            checkOutput("w8 sum", 32'(sum8), 32'(e8.s));
            checkOutput("w8 c_out", 32'(c_out8), 32'(e8.co));
            checkOutput("w8 ovf", 32'(ovf8), 32'(e8.ov));
`ifdef FULL_ADDER_SAMP_PARITY_EN
            checkOutput("w8 sum_par", 32'(sum_par8), 32'(^e8.s));
`endif
         end
      end
   end

   vec_t tbl1[8];
   vec_t tbl8[7];
   exp_t idle_e;
   exp_t last8;

   initial begin
      tbl1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1};
      tbl1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0};
      tbl1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0};
      tbl1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
      tbl1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0};
      tbl1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b1};
      tbl1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0};

      tbl8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl8[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl8[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
      tbl8[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl8[5] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl8[6] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0};
      idle_e  = '{8'h00, 1'b0, 1'b0};

      rst_n = 1'b0;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;

      // Reset state.
      #12;
      checkOutput("reset w1 sum", 32'(sum1), 32'd0);
      checkOutput("reset w1 out_valid", 32'(out_valid1), 32'd0);
      checkOutput("reset w1 carry_cnt", 32'(carry_cnt1), 32'd0);
      checkOutput("reset w8 sum", 32'(sum8), 32'd0);
      checkOutput("reset w8 c_out", 32'(c_out8), 32'd0);
      checkOutput("reset w8 ovf", 32'(ovf8), 32'd0);
      checkOutput("reset w8 out_valid", 32'(out_valid8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // All eight single-bit combinations back to back.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 1'b1, tbl1[i].a, tbl1[i].b, tbl1[i].c, '{tbl1[i].s, tbl1[i].co, tbl1[i].ov});
      end
      applyStimulus(1, 1'b0, 8'd0, 8'd0, 1'b0, idle_e);
      checkOutput("w1 carry_cnt after table", 32'(carry_cnt1), 32'd4);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(8, 1'b1, tbl8[i].a, tbl8[i].b, tbl8[i].c, '{tbl8[i].s, tbl8[i].co, tbl8[i].ov});
      end
      last8 = '{tbl8[6].s, tbl8[6].co, tbl8[6].ov};

      // Three idle cycles with garbage operands: outputs hold, out_valid drops.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(8, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), idle_e);
         @(posedge clk);
         #1;
         checkOutput("hold w8 out_valid", 32'(out_valid8), 32'd0);
         checkOutput("hold w8 sum", 32'(sum8), 32'(last8.s));
         checkOutput("hold w8 c_out", 32'(c_out8), 32'(last8.co));
         checkOutput("hold w8 ovf", 32'(ovf8), 32'(last8.ov));
         checkOutput("hold w8 carry_cnt", 32'(carry_cnt8), 32'd3);
      end

      // Reset lands between the operand edge and the next edge.
      applyStimulus(8, 1'b1, 8'hAA, 8'h55, 1'b1, model(8, 8'hAA, 8'h55, 1'b1));
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      in_valid8 = 1'b0;
      q8.delete();
      q1.delete();
      #1;
      checkOutput("midreset w8 sum", 32'(sum8), 32'd0);
      checkOutput("midreset w8 c_out", 32'(c_out8), 32'd0);
      checkOutput("midreset w8 out_valid", 32'(out_valid8), 32'd0);
      checkOutput("midreset w8 carry_cnt", 32'(carry_cnt8), 32'd0);
      checkOutput("midreset w1 carry_cnt", 32'(carry_cnt1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput("post-reset w8 out_valid", 32'(out_valid8), 32'd0);
      end

      // Saturate the carry counter.
      for (int i = 0; i < 65540; i++) begin
         applyStimulus(1, 1'b1, 8'd1, 8'd1, 1'b0, model(1, 8'd1, 8'd1, 1'b0));
      end
      applyStimulus(1, 1'b0, 8'd0, 8'd0, 1'b0, idle_e);
      checkOutput("w1 carry_cnt saturated", 32'(carry_cnt1), 32'hFFFF);

      applyStimulus(1, 1'b0, 8'd0, 8'd0, 1'b0, idle_e);
      applyStimulus(8, 1'b0, 8'd0, 8'd0, 1'b0, idle_e);
      checkOutput("w1 scoreboard drained", 32'(q1.size()), 32'd0);
      checkOutput("w8 scoreboard drained", 32'(q8.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
